// File: rtl/alu2_share_arbiter_if.sv
// Request/grant/result bundle between the four lab requesters and the shared
// 2-bit NAND/ADD unit.
interface alu2_share_arbiter_if;
    logic [3:0] req;
    logic [7:0] a_bus;
    logic [7:0] b_bus;
    logic [3:0] op_bus;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [3:0] result;
    logic [1:0] result_id;
    logic       busy;

    modport master (
        output req, a_bus, b_bus, op_bus,
        input  gnt, ack, result, result_id, busy
    );

    modport slave (
        input  req, a_bus, b_bus, op_bus,
        output gnt, ack, result, result_id, busy
    );
endinterface

// File: rtl/alu2_share_arbiter.sv
// Round-robin arbiter sharing one 2-bit NAND/ADD unit between four requesters.
// Each transaction runs grant/latch -> execute -> acknowledge, one in flight.
module alu2_share_arbiter (
    input  logic                  clk,
    input  logic                  reset,
    alu2_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] rr_ptr_q;
    logic [1:0] win_q;
    logic [1:0] a_q;
    logic [1:0] b_q;
    logic       op_q;
    logic [3:0] gnt_q;
    logic [3:0] ack_q;
    logic [3:0] result_q;
    logic [1:0] result_id_q;
    logic       busy_q;

    logic [1:0] winner_s;
    logic       found_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] alu_compute(input logic [1:0] a,
                                               input logic [1:0] b,
                                               input logic       op);
        logic [3:0] r;
        if (op) begin
            r = {1'b0, {1'b0, a} + {1'b0, b}};
        end else begin
            r = {2'b00, ~(a & b)};
        end
        return r;
    endfunction

    // Round-robin search starting at rr_ptr; the 2-bit index wraps naturally.
    always_comb begin
        winner_s = rr_ptr_q;
        found_s  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] idx;
            idx = rr_ptr_q + 2'(i);
            if (!found_s && bus.req[idx]) begin
                winner_s = idx;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Transaction sequencer with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 2'd0;
            win_q       <= 2'd0;
            a_q         <= 2'd0;
            b_q         <= 2'd0;
            op_q        <= 1'b0;
            gnt_q       <= 4'b0000;
            ack_q       <= 4'b0000;
            result_q    <= 4'b0000;
            result_id_q <= 2'd0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 4'b0000;
                    if (found_s) begin
                        win_q   <= winner_s;
                        a_q     <= bus.a_bus[{winner_s, 1'b0} +: 2];
                        b_q     <= bus.b_bus[{winner_s, 1'b0} +: 2];
                        op_q    <= bus.op_bus[winner_s];
                        gnt_q   <= onehot4(winner_s);
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end else begin
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    result_q    <= alu_compute(a_q, b_q, op_q);
                    result_id_q <= win_q;
                    ack_q       <= onehot4(win_q);
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    ack_q    <= 4'b0000;
                    gnt_q    <= 4'b0000;
                    rr_ptr_q <= win_q + 2'd1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    ack_q   <= 4'b0000;
                    gnt_q   <= 4'b0000;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.result    = result_q;
    assign bus.result_id = result_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu2_share_arbiter.sv
// Bench for alu2_share_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level reference model.
module tb_alu2_share_arbiter;

    logic clk;
    logic reset;
    alu2_share_arbiter_if bus_if ();

    alu2_share_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase counts cycles since the grant, 0 = no transaction.
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_win   = 0;
    int         m_a, m_b, m_op;
    logic [3:0] e_gnt = 4'd0, e_ack = 4'd0, e_result = 4'd0;
    logic [1:0] e_rid = 2'd0;
    logic       e_busy = 1'b0;
    int         ack_order[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic [3:0] rq, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] op);
        if (rst) begin
            m_phase = 0; m_ptr = 0;
            e_gnt = 4'd0; e_ack = 4'd0; e_result = 4'd0; e_rid = 2'd0; e_busy = 1'b0;
        end else if (m_phase == 0) begin
            e_ack = 4'd0;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (m_phase == 0 && rq[k]) begin
                    m_win = k;
                    m_a = (a >> (2 * k)) & 3;
                    m_b = (b >> (2 * k)) & 3;
                    m_op = op[k];
                    m_phase = 1;
                end
            end
            e_gnt  = (m_phase == 1) ? 4'(1 << m_win) : 4'd0;
            e_busy = (m_phase == 1);
        end else if (m_phase == 1) begin
            e_result = (m_op == 1) ? 4'(m_a + m_b) : 4'(3 - (m_a & m_b));
            e_rid    = 2'(m_win);
            e_ack    = 4'(1 << m_win);
            m_phase  = 2;
        end else begin
            e_ack = 4'd0; e_gnt = 4'd0; e_busy = 1'b0;
            m_ptr = (m_win + 1) % 4;
            m_phase = 0;
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] rq, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] op);
        reset = rst;
        bus_if.req = rq; bus_if.a_bus = a; bus_if.b_bus = b; bus_if.op_bus = op;
        @(posedge clk);
        model(rst, rq, a, b, op);
        #1;
        check("gnt",       8'(bus_if.gnt),       8'(e_gnt));
        check("ack",       8'(bus_if.ack),       8'(e_ack));
        check("result",    8'(bus_if.result),    8'(e_result));
        check("result_id", 8'(bus_if.result_id), 8'(e_rid));
        check("busy",      8'(bus_if.busy),      8'(e_busy));
        check("gnt_1hot",  8'($countones(bus_if.gnt) <= 1), 8'd1);
        if (bus_if.ack != 4'd0) ack_order.push_back(int'($clog2(bus_if.ack)));
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        bus_if.req = 4'd0; bus_if.a_bus = 8'd0; bus_if.b_bus = 8'd0; bus_if.op_bus = 4'd0;

        // Reset, then requester 0 NAND 11,01 -> 0010.
        step(1'b1, 4'b0000, 8'h00, 8'h00, 4'h0);
        step(1'b0, 4'b0001, 8'h03, 8'h01, 4'h0);
        check("t1_gnt", 8'(bus_if.gnt), 8'h01);
        step(1'b0, 4'b0001, 8'h03, 8'h01, 4'h0);
        check("t1_result", 8'(bus_if.result), 8'h02);
        check("t1_ack", 8'(bus_if.ack), 8'h01);
        step(1'b0, 4'b0000, 8'h00, 8'h00, 4'h0);
        check("t1_busy_low", 8'(bus_if.busy), 8'h00);
        check("t1_ack_gone", 8'(bus_if.ack), 8'h00);

        // Requester 2 ADD 3+3 -> 0110.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 8'h30, 8'h30, 4'h4);
        check("t2_rid", 8'(bus_if.result_id), 8'h02);
        check("t2_result", 8'(bus_if.result), 8'h06);

        // All four requesting after reset: order 0,1,2,3,0.
        step(1'b1, 4'b0000, 8'h00, 8'h00, 4'h0);
        ack_order.delete();
        for (int i = 0; i < 15; i++) step(1'b0, 4'b1111, 8'h5A, 8'hC3, 4'h6);
        check("t3_nacks", 8'(ack_order.size()), 8'd5);
        for (int i = 0; i < 5 && i < ack_order.size(); i++)
            check("t3_order", 8'(ack_order[i]), 8'(exp_order[i]));

        // Wrap: serve 3, then 1001 must pick 0.
        for (int i = 0; i < 6; i++) step(1'b0, 4'b1000, 8'h00, 8'h00, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1001, 8'h00, 8'h00, 4'h0);
        check("t4_rid", 8'(bus_if.result_id), 8'h00);

        // Requester 1 ADD 1+2 with operands and req changing after the grant.
        step(1'b0, 4'b0010, 8'h04, 8'h08, 4'h2);
        step(1'b0, 4'b0000, 8'hFF, 8'h00, 4'h0);
        check("t5_result", 8'(bus_if.result), 8'h03);
        check("t5_ack", 8'(bus_if.ack), 8'h02);
        step(1'b0, 4'b0000, 8'h00, 8'h00, 4'h0);

        // Reset during EXEC aborts with no ack; new request then served normally.
        step(1'b0, 4'b0100, 8'h10, 8'h20, 4'h4);
        step(1'b1, 4'b0100, 8'h10, 8'h20, 4'h4);
        check("t6_result", 8'(bus_if.result), 8'h00);
        check("t6_gnt", 8'(bus_if.gnt), 8'h00);
        step(1'b0, 4'b0000, 8'h00, 8'h00, 4'h0);
        check("t6_no_ack", 8'(bus_if.ack), 8'h00);
        step(1'b0, 4'b0100, 8'h10, 8'h20, 4'h4);
        check("t6_gnt2", 8'(bus_if.gnt), 8'h04);
        step(1'b0, 4'b0100, 8'h10, 8'h20, 4'h4);
        check("t6_result2", 8'(bus_if.result), 8'h03);
        step(1'b0, 4'b0000, 8'h00, 8'h00, 4'h0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), 8'($urandom),
                 8'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu2_share_arbiter.md
Name: alu2_share_arbiter

Overview:
- Shares one 2-bit operation unit between 4 requesters using round-robin arbitration.
- The unit computes either a bitwise NAND or an ADD; the result is zero-extended to 4 bits.
- Sequences each transaction: grant, operand latch, execute, acknowledge.
- Sits between lab test requesters (switch/controller ports) and the shared 2-bit NAND/adder datapath.

Parameters:
- NREQ, 4, number of requesters; fixed at 4, and the id width is 2 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  per-requester request, bit i = requester i.
- a_bus  input  8  operand A per requester; bits [2i+1:2i] belong to requester i.
- b_bus  input  8  operand B per requester; same packing as a_bus.
- op_bus  input  4  per-requester operation select: 0 = NAND, 1 = ADD.
- gnt  output  4  one-hot grant, held from latch cycle through ack.
- ack  output  4  one-hot, one-cycle completion pulse to the served requester.
- result  output  4  last computed result, held until the next completion.
- result_id  output  2  index of the requester that owns result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - Synchronous, active-high, one clock.
  - Takes priority over everything, including a transaction in progress.
  - state=IDLE, rr_ptr=0, gnt=0, ack=0, result=0, result_id=0, busy=0.
  - An aborted transaction is dropped with no ack. The requester must re-request.
- States: IDLE, EXEC, DONE, encoded as 2 bits; the fourth encoding goes to IDLE.
- IDLE:
  - When req != 0, pick the winner: the first requester with req high, searching rr_ptr, rr_ptr+1, ... modulo 4.
  - Latch a, b and op of the winner into internal registers.
  - Set gnt to one-hot(winner) and move to EXEC. busy rises in the same cycle the state leaves IDLE.
  - When req == 0, stay in IDLE with gnt=0.
- EXEC:
  - Register the latched operation:
    - op=0: result = {2'b00, ~(a[1]&b[1]), ~(a[0]&b[0])}.
    - op=1: result = {1'b0, a+b}, with the 3-bit sum zero-extended.
  - Set result_id to the winner and move to DONE.
- DONE:
  - ack[winner]=1 for exactly this cycle.
  - rr_ptr = winner+1 modulo 4 (winner 3 wraps to 0).
  - Clear gnt and move to IDLE.
- Latency: req sampled high in IDLE at cycle T gives gnt at T+1, result valid at T+2, and ack visible during T+2..T+3. This is one 3-cycle transaction, with at most one transaction in flight.
- Throughput: back-to-back transactions start every 3 cycles, because IDLE re-arbitrates on the cycle after DONE.
- Requester rules:
  - Hold req and the operands stable until ack is seen.
  - Drop req the cycle after ack, or keep it high to queue another transaction.
- Operands are sampled only at the IDLE grant edge. Operand changes or a req drop after that edge do not affect the current transaction, and it completes with ack.
- Fairness:
  - Requests that arrive simultaneously are served in round-robin order from rr_ptr.
  - A requester that holds req continuously waits at most 3 other transactions.
- result and result_id stay stable outside the EXEC update edge. They are not cleared by returning to IDLE.
- gnt and ack are always zero or one-hot.

Test Plan:
- Reset then a single request: req=0001, a0=2'b11, b0=2'b01, op0=0.
  - gnt=0001 at T+1, result=4'b0010 at T+2, ack=0001 for one cycle, busy low at T+3.
- ADD overflow: requester 2 with a=3, b=3, op=1 → result=4'b0110, result_id=2, ack=0100.
- Simultaneous requests: req=1111 held after reset → service order 0,1,2,3,0, with acks every 3 cycles; gnt is never multi-hot.
- Round-robin wrap: serve requester 3, then raise req=1001 → requester 0 served next, not 3.
- Mid-operation change: requester 1 latched with a=1, b=2, op=1; a_bus and req change during EXEC → result=4'b0011, ack=0010.
- Reset during EXEC: assert reset for one cycle → ack never pulses, all outputs 0, rr_ptr=0. A new req=0100 is served with normal 3-cycle latency.
